prog_loader: RTL and testbench

- Byte-stream program loader that sits directly upstream of the instruction ROM in riscv_soc.
- Receives a framed program image over a valid/ready byte interface (UART RX or debug bridge) and assembles little-endian 32-bit instructions.
- Writes the instructions into the ROM write port and holds the core in reset until a load completes with a good checksum.
- Gives a hardware replacement for preloading the ROM from a file.

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_asm.sv | 72 +++++++
 rtl/prog_loader.sv | 169 ++++++++++++++++
 tb/tb_prog_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states, frame magic and
// word-count width, plus small state classification helpers.
package prog_loader_pkg;

  localparam int         COUNT_WIDTH  = 16;
  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    FIN,
    FAIL
  } state_e;

  // States in which the loader takes a byte from the stream.
  function automatic logic accepts_bytes(input state_e s);
    return (s != FIN) && (s != FAIL);
  endfunction

  // States that belong to a frame being received.
  function automatic logic in_frame(input state_e s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_asm.sv
// Byte-to-word assembler: places payload bytes little-endian into a 32-bit
// word, pulses word_valid the cycle after the fourth byte and keeps a
// running XOR of every payload byte for the frame checksum.
module prog_loader_asm
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_lane,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] low_q, low_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic        valid_q, valid_d;

  // Next-state: lane placement, word completion and checksum accumulation.
  always_comb begin
    lane_d  = lane_q;
    low_d   = low_q;
    word_d  = word_q;
    csum_d  = csum_q;
    valid_d = 1'b0;
    if (clear) begin
      lane_d = 2'd0;
      low_d  = 24'd0;
      csum_d = 8'd0;
    end else if (byte_valid) begin
      csum_d = csum_q ^ byte_data;
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    low_d[7:0]   = byte_data;
        2'd1:    low_d[15:8]  = byte_data;
        2'd2:    low_d[23:16] = byte_data;
        default: begin
          word_d  = {byte_data, low_q};
          valid_d = 1'b1;
        end
      endcase
    end
  end

  // Register the assembler state; the completed word is held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= 2'd0;
      low_q   <= 24'd0;
      word_q  <= 32'd0;
      csum_q  <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      low_q   <= low_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      valid_q <= valid_d;
    end
  end

  assign last_lane  = (lane_q == 2'd3);
  assign word_valid = valid_q;
  assign word       = word_q;
  assign csum       = csum_q;

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader feeding the instruction ROM write port.
// Frame: A5, count lo, count hi, 4*count payload bytes, XOR checksum.
// Holds the core in reset until a frame completes with a good checksum.
// Optional inter-byte timeout enabled by defining PROG_LOADER_TIMEOUT_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int INST_WIDTH     = 32,
  parameter int MAX_WORDS      = 4096,
  parameter int BOOT_HOLD      = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_waddr,
  output logic [INST_WIDTH-1:0] rom_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [COUNT_WIDTH-1:0] MAX_CNT       = COUNT_WIDTH'(MAX_WORDS);
  localparam logic                   BOOT_HOLD_BIT = (BOOT_HOLD != 0);

  if (INST_WIDTH != 32 || MAX_WORDS < 1 || MAX_WORDS > 65535 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("prog_loader: unsupported parameter combination");
  end

  state_e                  state_q, state_d;
  logic                    rx_ready_q, rx_ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    core_hold_q, core_hold_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic [COUNT_WIDTH-1:0]  idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   rom_waddr_q, rom_waddr_d;
  logic [COUNT_WIDTH-1:0]  len_full;
  logic                    acc;
  logic                    asm_clear;
  logic                    asm_byte_valid;
  logic                    asm_last_lane;
  logic                    asm_word_valid;
  logic [31:0]             asm_word;
  logic [7:0]              asm_csum;

`ifdef PROG_LOADER_TIMEOUT_EN
  localparam logic [31:0] TMR_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmr_q, tmr_d;
`endif

  assign acc            = rx_valid && rx_ready_q;
  assign asm_clear      = acc && (state_q == IDLE) && (rx_data == LOADER_MAGIC);
  assign asm_byte_valid = acc && (state_q == DATA);

  prog_loader_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (asm_byte_valid),
    .byte_data  (rx_data),
    .last_lane  (asm_last_lane),
    .word_valid (asm_word_valid),
    .word       (asm_word),
    .csum       (asm_csum)
  );

  // Frame FSM next-state, word addressing and status outputs derived from the next state.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    rom_waddr_d = rom_waddr_q;
    err_d       = err_q;
    core_hold_d = core_hold_q;
    len_full    = {rx_data, count_q[7:0]};
`ifdef PROG_LOADER_TIMEOUT_EN
    tmr_d = (!busy_q || acc) ? 32'd0 : tmr_q + 32'd1;
`endif
    case (state_q)
      IDLE: begin
        if (asm_clear) begin
          err_d       = 1'b0;
          core_hold_d = 1'b1;
          idx_d       = '0;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (acc) begin
          count_d[7:0] = rx_data;
          state_d      = LEN_HI;
        end
      end
      LEN_HI: begin
        if (acc) begin
          count_d = len_full;
          state_d = (len_full == '0 || len_full > MAX_CNT) ? FAIL : DATA;
        end
      end
      DATA: begin
        if (acc && asm_last_lane) begin
          rom_waddr_d = ADDR_WIDTH'({idx_q, 2'b00});
          idx_d       = idx_q + 1'b1;
          if (idx_q == count_q - 1'b1) state_d = CSUM;
        end
      end
      CSUM: begin
        if (acc) state_d = (rx_data == asm_csum) ? FIN : FAIL;
      end
      default: state_d = IDLE;
    endcase
`ifdef PROG_LOADER_TIMEOUT_EN
    if (busy_q && !acc && tmr_q == TMR_LAST) state_d = FAIL;
`endif
    done_d = (state_d == FIN);
    if (state_d == FIN) core_hold_d = 1'b0;
    if (state_d == FAIL) err_d = 1'b1;
    busy_d     = in_frame(state_d);
    rx_ready_d = accepts_bytes(state_d);
  end

  // Single register stage for the FSM and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      core_hold_q <= BOOT_HOLD_BIT;
      count_q     <= '0;
      idx_q       <= '0;
      rom_waddr_q <= '0;
`ifdef PROG_LOADER_TIMEOUT_EN
      tmr_q       <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      core_hold_q <= core_hold_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      rom_waddr_q <= rom_waddr_d;
`ifdef PROG_LOADER_TIMEOUT_EN
      tmr_q       <= tmr_d;
`endif
    end
  end

  assign rx_ready  = rx_ready_q;
  assign rom_we    = asm_word_valid;
  assign rom_waddr = rom_waddr_q;
  assign rom_wdata = asm_word;
  assign core_hold = core_hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a frame-level reference model turns each
// byte stream into expected ROM writes and done/err events; a monitor pops
// and compares them whenever the loader presents rom_we, done or a new err.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int         MAXW    = 4096;
  localparam int         TMO     = 50;
  localparam logic [7:0] EV_DONE = 8'h01;
  localparam logic [7:0] EV_ERR  = 8'h02;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        rom_we;
  logic [31:0] rom_waddr;
  logic [31:0] rom_wdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        err;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_wr[$];
  logic [7:0]  exp_ev[$];
  logic [7:0]  stim[$];
  logic [31:0] frame_words[$];
  logic        m_hold = 1'b0;
  logic        m_err = 1'b0;
  logic        err_prev = 1'b0;
  logic [63:0] mon_wr;
  logic [7:0]  mon_ev;

  always #5 clk = ~clk;

  prog_loader #(
    .ADDR_WIDTH     (32),
    .INST_WIDTH     (32),
    .MAX_WORDS      (MAXW),
    .BOOT_HOLD      (0),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rom_we    (rom_we),
    .rom_waddr (rom_waddr),
    .rom_wdata (rom_wdata),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: compare every ROM write and every done/err event against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (rom_we) checkOutput("rom_we_in_reset", {31'd0, rom_we}, 32'd0);
      err_prev = 1'b0;
    end else begin
      if (rom_we) begin
        if (exp_wr.size() == 0) checkOutput("spurious_rom_we", {31'd0, rom_we}, 32'd0);
        else begin
          mon_wr = exp_wr.pop_front();
          checkOutput("rom_waddr", rom_waddr, mon_wr[63:32]);
          checkOutput("rom_wdata", rom_wdata, mon_wr[31:0]);
        end
      end
      if (done) begin
        if (exp_ev.size() == 0) checkOutput("spurious_done", {31'd0, done}, 32'd0);
        else begin
          mon_ev = exp_ev.pop_front();
          checkOutput("event_done", {24'd0, EV_DONE}, {24'd0, mon_ev});
        end
      end
      if (err && !err_prev) begin
        if (exp_ev.size() == 0) checkOutput("spurious_err", {31'd0, err}, 32'd0);
        else begin
          mon_ev = exp_ev.pop_front();
          checkOutput("event_err", {24'd0, EV_ERR}, {24'd0, mon_ev});
        end
      end
      err_prev = err;
    end
  end

  // Reference model: walk complete frames in stim and predict writes, events, hold and err.
  task automatic modelStream();
    int p = 0;
    int n;
    logic [7:0]  x;
    logic [31:0] w;
    while (p < stim.size()) begin
      if (stim[p] != LOADER_MAGIC) p++;
      else begin
        m_err  = 1'b0;
        m_hold = 1'b1;
        n = int'({stim[p+2], stim[p+1]});
        p += 3;
        if (n == 0 || n > MAXW) begin
          m_err = 1'b1;
          exp_ev.push_back(EV_ERR);
        end else begin
          x = 8'h00;
          for (int k = 0; k < n; k++) begin
            w = {stim[p+3], stim[p+2], stim[p+1], stim[p]};
            x = x ^ stim[p] ^ stim[p+1] ^ stim[p+2] ^ stim[p+3];
            exp_wr.push_back({32'(k * 4), w});
            p += 4;
          end
          if (stim[p] == x) begin
            m_hold = 1'b0;
            exp_ev.push_back(EV_DONE);
          end else begin
            m_err = 1'b1;
            exp_ev.push_back(EV_ERR);
          end
          p++;
        end
      end
    end
  endtask

  task automatic addFrame(input logic corrupt);
    logic [7:0] x = 8'h00;
    int n = frame_words.size();
    logic [31:0] fw;
    stim.push_back(LOADER_MAGIC);
    stim.push_back(8'(n));
    stim.push_back(8'(n >> 8));
    foreach (frame_words[i]) begin
      fw = frame_words[i];
      for (int b = 0; b < 4; b++) begin
        stim.push_back(fw[8*b +: 8]);
        x = x ^ fw[8*b +: 8];
      end
    end
    stim.push_back(corrupt ? (x ^ 8'h01) : x);
  endtask

  task automatic pushSingle(input logic [7:0] cs);
    stim.push_back(8'hA5); stim.push_back(8'h01); stim.push_back(8'h00);
    stim.push_back(8'h93); stim.push_back(8'h0D); stim.push_back(8'h10);
    stim.push_back(8'h00); stim.push_back(cs);
  endtask

  // Entered and left on a falling edge; the byte transfers on the posedge in between.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int waited = 0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) checkOutput("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int max_gap, input string tag);
    int cyc = 0;
    modelStream();
    foreach (stim[i]) sendByte(stim[i], $urandom_range(0, max_gap));
    stim.delete();
    while ((exp_wr.size() != 0 || exp_ev.size() != 0 || busy || !rx_ready) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_pending"}, 32'(exp_wr.size() + exp_ev.size()), 32'd0);
    checkOutput({tag, "_core_hold"}, {31'd0, core_hold}, {31'd0, m_hold});
    checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    checkOutput({tag, "_rom_we"}, {31'd0, rom_we}, 32'd0);
    checkOutput({tag, "_rom_waddr"}, rom_waddr, 32'd0);
    checkOutput({tag, "_rom_wdata"}, rom_wdata, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
    checkOutput({tag, "_core_hold"}, {31'd0, core_hold}, 32'd0);
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState(tag);
    rst = 1'b0;
    m_hold = 1'b0;
    m_err = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nw;
    int ng;
    logic [7:0] gb;
    logic corrupt;

    @(negedge clk);
    doReset("por");

    pushSingle(8'h8E);
    applyStimulus(0, "single");

    pushSingle(8'h8F);
    applyStimulus(0, "bad_csum");
    pushSingle(8'h8E);
    applyStimulus(0, "recover");

    stim.push_back(8'hA5); stim.push_back(8'h00); stim.push_back(8'h00);
    applyStimulus(0, "len_zero");

    stim.push_back(8'hA5); stim.push_back(8'h01); stim.push_back(8'h10);
    applyStimulus(0, "len_over");

    frame_words.delete();
    frame_words.push_back(32'h00100D93);
    frame_words.push_back(32'h01BD8E33);
    addFrame(1'b0);
    applyStimulus(0, "two_words");

    stim.push_back(8'h00); stim.push_back(8'hFF); stim.push_back(8'h5A);
    pushSingle(8'h8E);
    applyStimulus(2, "garbage");

    for (int it = 0; it < 10; it++) begin
      nw = $urandom_range(1, 6);
      ng = $urandom_range(0, 2);
      corrupt = ($urandom_range(0, 3) == 0);
      frame_words.delete();
      for (int k = 0; k < nw; k++) frame_words.push_back($urandom());
      for (int g = 0; g < ng; g++) begin
        gb = 8'($urandom());
        if (gb == LOADER_MAGIC) gb = 8'h3C;
        stim.push_back(gb);
      end
      addFrame(corrupt);
      applyStimulus(5, "rand_gaps");
      addFrame(corrupt);
      applyStimulus(0, "rand_full");
    end

    // Stall after two payload bytes.
    stim.push_back(8'hA5); stim.push_back(8'h01); stim.push_back(8'h00);
    stim.push_back(8'h93); stim.push_back(8'h0D);
    foreach (stim[i]) sendByte(stim[i], 0);
    stim.delete();
`ifdef PROG_LOADER_TIMEOUT_EN
    exp_ev.push_back(EV_ERR);
    repeat (TMO - 1) @(negedge clk);
    checkOutput("timeout_before", {31'd0, err}, 32'd0);
    @(negedge clk);
    checkOutput("timeout_err", {31'd0, err}, 32'd1);
    checkOutput("timeout_hold", {31'd0, core_hold}, 32'd1);
`else
    repeat (TMO + 10) @(negedge clk);
    checkOutput("stall_busy", {31'd0, busy}, 32'd1);
    checkOutput("stall_err", {31'd0, err}, 32'd0);
`endif
    doReset("stall_rst");

    // Reset after six of eight bytes.
    stim.push_back(8'hA5); stim.push_back(8'h01); stim.push_back(8'h00);
    stim.push_back(8'h93); stim.push_back(8'h0D); stim.push_back(8'h10);
    foreach (stim[i]) sendByte(stim[i], 0);
    stim.delete();
    doReset("mid_rst");
    repeat (5) @(negedge clk);
    checkOutput("mid_rst_no_we", {31'd0, rom_we}, 32'd0);
    pushSingle(8'h8E);
    applyStimulus(3, "after_rst");

    checkOutput("final_writes_left", 32'(exp_wr.size()), 32'd0);
    checkOutput("final_events_left", 32'(exp_ev.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
